// File: rtl/permutation_sequencer.sv
// Round sequencer and state register for the ASCON permutation.
// Loads a 320-bit state, steps the round index and feeds each full round back until round 11.
module permutation_sequencer #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [4:0][63:0] i_state,
  input  logic [4:0][63:0] i_round_state,
  output logic [3:0]       o_round,
  output logic [4:0][63:0] o_round_state,
  output logic [4:0][63:0] o_state,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy
);

  if (NB_ROUNDS_A < 1 || NB_ROUNDS_A > 12) begin : g_bad_rounds_a
    $error("NB_ROUNDS_A must be in 1..12");
  end
  if (NB_ROUNDS_B < 1 || NB_ROUNDS_B > 12) begin : g_bad_rounds_b
    $error("NB_ROUNDS_B must be in 1..12");
  end

  // Jobs always finish on round 11, so a shorter permutation starts later in the table.
  localparam logic [3:0] START_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t       fsm;
  logic [3:0] start_idx;

  assign start_idx = i_mode ? START_B : START_A;
  assign o_state   = o_round_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm           <= IDLE;
      o_round       <= '0;
      o_round_state <= '0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (i_start) begin
            o_round_state <= i_state;
            o_round       <= start_idx;
            o_busy        <= 1'b1;
            fsm           <= RUN;
          end
        end
        RUN: begin
          o_round_state <= i_round_state;
          if (o_round == LAST_ROUND) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            fsm     <= DONE;
          end else begin
            o_round <= o_round + 4'd1;
          end
        end
        DONE: begin
          // A start coinciding with the accept launches the next job with no idle cycle.
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_start) begin
              o_round_state <= i_state;
              o_round       <= start_idx;
              o_busy        <= 1'b1;
              fsm           <= RUN;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm     <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench: a stub round function XORs the ASCON round constant into word 2,
// and a reference model predicts the result from the constant table directly.
module tb_permutation_sequencer;

  localparam int NA  = 12;
  localparam int NB  = 6;
  localparam int NB8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, mode, ready, valid, busy;
  logic [4:0][63:0] st_in, rs_in, rstate, ostate;
  logic [3:0]       rnd;

  logic             start8, ready8, valid8, busy8;
  logic [4:0][63:0] st_in8, rs_in8, rstate8, ostate8;
  logic [3:0]       rnd8;

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] rc_of(input int r);
    case (r)
      0: return 64'hf0;  1: return 64'he1;  2: return 64'hd2;  3: return 64'hc3;
      4: return 64'hb4;  5: return 64'ha5;  6: return 64'h96;  7: return 64'h87;
      8: return 64'h78;  9: return 64'h69; 10: return 64'h5a; 11: return 64'h4b;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
    logic [319:0] t;
    t = s;
    t[191:128] = t[191:128] ^ rc_of(int'(r));
    return t;
  endfunction

  // Reference: an n-round job applies constants 12-n .. 11 to word 2 and nothing else.
  function automatic logic [319:0] model(input logic [319:0] s, input int n);
    logic [63:0]  k;
    logic [319:0] t;
    k = '0;
    for (int r = 12 - n; r < 12; r++) k = k ^ rc_of(r);
    t = s;
    t[191:128] = t[191:128] ^ k;
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  assign rs_in  = round_fn(rstate, rnd);
  assign rs_in8 = round_fn(rstate8, rnd8);

  permutation_sequencer #(.NB_ROUNDS_A(NA), .NB_ROUNDS_B(NB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_state(st_in),
    .i_round_state(rs_in), .o_round(rnd), .o_round_state(rstate), .o_state(ostate),
    .o_valid(valid), .i_ready(ready), .o_busy(busy)
  );

  permutation_sequencer #(.NB_ROUNDS_A(NA), .NB_ROUNDS_B(NB8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_mode(1'b1), .i_state(st_in8),
    .i_round_state(rs_in8), .o_round(rnd8), .o_round_state(rstate8), .o_state(ostate8),
    .o_valid(valid8), .i_ready(ready8), .o_busy(busy8)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts a job (optionally together with accepting a pending result), follows every round,
  // then holds the result for `stall` cycles; `poke` fires stray starts in RUN and DONE.
  task automatic do_job(input logic m, input logic [319:0] s, input int stall,
                        input bit poke, input bit b2b);
    int n;
    logic [319:0] e;
    n = m ? NB : NA;
    e = model(s, n);
    @(negedge clk);
    start = 1'b1; mode = m; st_in = s; ready = b2b;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b0; st_in = rand320();
    check("start_busy", 320'(busy), 320'(1));
    check("start_valid", 320'(valid), 320'(0));
    check("start_round", 320'(rnd), 320'(12 - n));
    check("load_state", rstate, s);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      start = poke && (i == 1); mode = ~m; st_in = rand320();
      @(posedge clk); #1;
      check("run_round", 320'(rnd), 320'(12 - n + i));
      check("run_busy", 320'(busy), 320'(1));
      check("run_valid", 320'(valid), 320'(0));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_valid", 320'(valid), 320'(1));
    check("done_busy", 320'(busy), 320'(0));
    check("done_round", 320'(rnd), 320'(11));
    check("result", ostate, e);
    for (int j = 0; j < stall; j++) begin
      @(negedge clk);
      start = poke; st_in = rand320();
      @(posedge clk); #1;
      check("stall_valid", 320'(valid), 320'(1));
      check("stall_state", ostate, e);
    end
    @(negedge clk);
    start = 1'b0;
    $display("job mode=%0d rounds=%0d stall=%0d poke=%0d b2b=%0d result=%h", m, n, stall, poke, b2b, ostate);
  endtask

  task automatic accept();
    @(negedge clk);
    ready = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    ready = 1'b0;
    check("accept_valid", 320'(valid), 320'(0));
    check("accept_busy", 320'(busy), 320'(0));
  endtask

  logic [319:0] s;

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b0; st_in = '0;
    start8 = 1'b0; ready8 = 1'b0; st_in8 = '0;
    #1 rst = 1'b1;
    #20;
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_valid", 320'(valid), 320'(0));
    check("rst_round", 320'(rnd), 320'(0));
    check("rst_state", rstate, 320'(0));
    @(negedge clk);
    rst = 1'b0;

    // p^a: constants cancel, word 2 comes back unchanged
    s = rand320();
    s[191:128] = 64'h0123456789ABCDEF;
    do_job(1'b0, s, 0, 1'b0, 1'b0);
    check("pa_word2", 320'(ostate[2]), 320'(64'h0123456789ABCDEF));
    check("pa_others", {ostate[4], ostate[3], ostate[1], ostate[0]},
          {s[319:192], s[127:0]});
    accept();

    // p^b with 6 rounds: word 2 ends as 0x11
    s = rand320();
    s[191:128] = 64'h0;
    do_job(1'b1, s, 0, 1'b0, 1'b0);
    check("pb6_word2", 320'(ostate[2]), 320'(64'h11));
    accept();

    // Backpressure with stray starts in RUN and DONE
    do_job(1'b0, rand320(), 5, 1'b1, 1'b0);
    accept();

    // Back-to-back: accept and start on the same DONE cycle
    do_job(1'b0, rand320(), 0, 1'b0, 1'b0);
    do_job(1'b1, rand320(), 2, 1'b0, 1'b1);
    do_job(1'b0, rand320(), 1, 1'b0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      bit b2b;
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) accept();
      do_job(1'($urandom_range(0, 1)), rand320(), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), b2b);
    end
    accept();

    // Reset in the middle of a p^a job
    @(negedge clk);
    start = 1'b1; mode = 1'b0; st_in = rand320();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && rnd != 4'd7; c++) begin
      @(posedge clk); #1;
    end
    check("reach_round7", 320'(rnd), 320'(7));
    #2 rst = 1'b1;
    #1;
    check("async_busy", 320'(busy), 320'(0));
    check("async_valid", 320'(valid), 320'(0));
    check("async_round", 320'(rnd), 320'(0));
    check("async_state", rstate, 320'(0));
    $display("reset mid-job busy=%0d valid=%0d round=%0d", busy, valid, rnd);
    @(negedge clk);
    rst = 1'b0;
    do_job(1'b0, rand320(), 1, 1'b0, 1'b0);
    accept();

    // p^b with 8 rounds on the second instance: word 2 ends as 0
    s = rand320();
    s[191:128] = 64'h0;
    @(negedge clk);
    start8 = 1'b1; st_in8 = s;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("pb8_start_round", 320'(rnd8), 320'(4));
    for (int i = 1; i < NB8; i++) begin
      @(posedge clk); #1;
      check("pb8_round", 320'(rnd8), 320'(4 + i));
      check("pb8_valid_low", 320'(valid8), 320'(0));
    end
    @(posedge clk); #1;
    check("pb8_valid", 320'(valid8), 320'(1));
    check("pb8_word2", 320'(ostate8[2]), 320'(64'h0));
    check("pb8_result", ostate8, model(s, NB8));
    $display("job8 rounds=%0d result=%h", NB8, ostate8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/permutation_sequencer.md
Name: permutation_sequencer

Overview:
- Round sequencer and state register for the ASCON permutation.
- Loads a 320-bit state and drives the round index and registered state into the constant-addition stage.
- Feeds the result of the full round function (constant addition, substitution, diffusion) back into the state register once per cycle until the last round, then presents the result with a valid/ready handshake.
- Sits directly upstream of the constant adder and closes the round loop.

Parameters:
- NB_ROUNDS_A, 12, round count for mode 0 (p^a); legal 1..12.
- NB_ROUNDS_B, 6, round count for mode 1 (p^b); legal 1..12.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  start request, sampled only when a load is permitted.
- i_mode  in  1  0 selects NB_ROUNDS_A, 1 selects NB_ROUNDS_B; sampled with i_start.
- i_state  in  t_state_array (5x64)  state to permute; sampled with i_start.
- i_round_state  in  t_state_array  combinational output of one full round applied to o_round_state.
- o_round  out  4  round-constant index to the constant adder (ROUND_CONSTANTS index).
- o_round_state  out  t_state_array  registered state to the constant adder.
- o_state  out  t_state_array  permutation result; equals o_round_state, meaningful while o_valid=1.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_busy  out  1  high in RUN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - o_round = 0; all 5 state words = 0.
  - o_valid = 0; o_busy = 0.
  - Reset asserted mid-RUN or in DONE aborts immediately; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 loads the state register with i_state.
  - Loads the round counter with start index s = 12 - N, where N = NB_ROUNDS_A if i_mode=0, else NB_ROUNDS_B.
  - Next state is RUN.
- RUN:
  - Every cycle, the state register loads i_round_state.
  - If o_round == 11, next state is DONE; otherwise o_round increments by 1.
  - i_start is ignored.
- DONE:
  - o_valid = 1; state register and counter hold.
  - On i_ready=1, next state is IDLE.
  - If i_start=1 in the same cycle as i_ready=1, the new job loads immediately (as from IDLE) and the FSM goes to RUN; back-to-back operation has no bubble.
  - i_start without i_ready is ignored.
- Round sequence: o_round steps s, s+1, ..., 11. Exactly N applications of i_round_state; the counter never exceeds 11 and never wraps.
- Latency: start accepted on edge k gives o_valid=1 after edge k+N. Busy window is N cycles.
- o_busy = (state == RUN); o_valid = (state == DONE), both registered.
- o_round holds its last value in IDLE and DONE. The downstream stage ignores it outside RUN.
- Parameter values outside 1..12 fail an elaboration-time assertion.

Test Plan:
- Reset, then a single job:
  - Stimulus: stub round function adds only the round constant to word 2; i_mode=0; word2 = 0x0123456789ABCDEF.
  - Required: o_round steps 0..11; o_valid rises after exactly 12 cycles; o_state word2 = 0x0123456789ABCDEF (XOR of all 12 constants = 0x00); other words unchanged.
- Same stub, i_mode=1 with NB_ROUNDS_B=6, word2 = 0:
  - Required: o_round steps 6..11; o_valid after 6 cycles; word2 = 0x11.
- Same stub, i_mode=1 with NB_ROUNDS_B=8, word2 = 0:
  - Required: o_round steps 4..11; o_valid after 8 cycles; word2 = 0.
- Backpressure:
  - Stimulus: i_ready held 0 for 5 cycles after o_valid; i_start pulsed during RUN and during DONE.
  - Required: o_state stable; o_valid held; both starts ignored; result accepted on the first i_ready=1.
- Back-to-back:
  - Stimulus: i_ready=1 and i_start=1 in the same DONE cycle.
  - Required: the next job's first round runs on the following cycle; no IDLE cycle.
- Reset mid-operation:
  - Stimulus: i_rst asserted at round 7 of a p^a job.
  - Required: asynchronously o_busy=0, o_valid=0, o_round=0, state=0; a job started after reset completes correctly.
